// File: rtl/pipeline_sequencer.sv
// Pipeline hazard and memory-wait sequencer.
// Combinational operand forwarding plus a small FSM that freezes the pipe while
// data memory is busy and latches a sticky error if the access never completes.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// RUN      | normal flow: load-use stall and branch flush rules apply
// MEM_WAIT | data access outstanding: F/D/E/M held, bubble into W
// ERROR    | access timed out: pipe frozen, mem_err set, exit by reset only
module pipeline_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [1:0]       result_src_e,
    input  logic             pcsrc_e,
    input  logic [4:0]       rd_m,
    input  logic             regwrite_m,
    input  logic [4:0]       rd_w,
    input  logic             regwrite_w,
    input  logic             mem_req_m,
    input  logic             mem_ready,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_ERROR    = 2'd2;

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_next;
    logic            load_use;
    logic            mem_wait_start;

    // Forwarding depends only on pipeline register fields, never on mem_ready.
    always_comb begin
        forward_a_e = 2'b00;
        if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs1_e))
            forward_a_e = 2'b10;
        else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs1_e))
            forward_a_e = 2'b01;
    end

    // Same selection for the second execute operand.
    always_comb begin
        forward_b_e = 2'b00;
        if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs2_e))
            forward_b_e = 2'b10;
        else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs2_e))
            forward_b_e = 2'b01;
    end

    assign load_use = (result_src_e == 2'b01) && (rd_e != 5'd0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

    // The cycle that discovers the stall already freezes the pipe.
    assign mem_wait_start = (state == S_RUN) && mem_req_m && !mem_ready;

    // Next-state and timeout counter. The triggering RUN cycle counts as the
    // first waited cycle, so the counter enters MEM_WAIT holding 1.
    always_comb begin
        state_next  = state;
        to_cnt_next = to_cnt;
        case (state)
            S_RUN: begin
                if (mem_wait_start) begin
                    to_cnt_next = TO_W'(1);
                    state_next  = (MEM_TIMEOUT <= 1) ? S_ERROR : S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (mem_ready) begin
                    state_next  = S_RUN;
                    to_cnt_next = '0;
                end else if (to_cnt >= TO_LAST) begin
                    state_next = S_ERROR;
                end else begin
                    to_cnt_next = to_cnt + TO_W'(1);
                end
            end
            S_ERROR: state_next = S_ERROR;
            default: begin
                state_next  = S_RUN;
                to_cnt_next = '0;
            end
        endcase
    end

    // State, timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RUN;
            to_cnt  <= '0;
            mem_err <= 1'b0;
        end else begin
            state  <= state_next;
            to_cnt <= to_cnt_next;
            if (state_next == S_ERROR)
                mem_err <= 1'b1;
        end
    end

    // Stage controls. A memory wait overrides everything; in RUN a load-use
    // stall and a branch flush may combine. A branch seen during a wait stays
    // parked in execute (stall_e) and flushes on the first RUN cycle.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (rst_n) begin
            if ((state != S_RUN) || mem_wait_start) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else begin
                stall_f = load_use;
                stall_d = load_use;
                flush_e = load_use | pcsrc_e;
                flush_d = pcsrc_e;
            end
        end
    end

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (stall_f && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: a table of single-cycle RUN
// vectors followed by hand-written multi-cycle wait, timeout, reset and
// saturation sequences. Expectations go through a scoreboard queue.
module tb_pipeline_sequencer;

    localparam int CNT_W = 8;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] result_src_e;
    logic       pcsrc_e, regwrite_m, regwrite_w, mem_req_m, mem_ready;
    logic [1:0] forward_a_e, forward_b_e;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w, mem_err;
    logic [CNT_W-1:0] stall_cycles;

    pipeline_sequencer #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .result_src_e(result_src_e), .pcsrc_e(pcsrc_e),
        .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .mem_req_m(mem_req_m), .mem_ready(mem_ready),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
        logic [1:0] rsrc;
        logic       pc;
        logic [4:0] rd_m;
        logic       rw_m;
        logic [4:0] rd_w;
        logic       rw_w;
        logic       mreq, mrdy;
        logic [1:0] fa, fb;
        logic [3:0] st;
        logic [2:0] fl;
        int         sc;
    } vec_t;

    typedef struct {
        string      nm;
        logic [1:0] fa, fb;
        logic [3:0] st;
        logic [2:0] fl;
        logic       err;
        int         sc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[13];

    function automatic vec_t mk(
        input logic [4:0] a_rs1_d, a_rs2_d, a_rs1_e, a_rs2_e, a_rd_e,
        input logic [1:0] a_rsrc, input logic a_pc,
        input logic [4:0] a_rd_m, input logic a_rw_m,
        input logic [4:0] a_rd_w, input logic a_rw_w,
        input logic a_mreq, a_mrdy,
        input logic [1:0] a_fa, a_fb, input logic [3:0] a_st,
        input logic [2:0] a_fl, input int a_sc);
        vec_t v;
        v.rs1_d = a_rs1_d; v.rs2_d = a_rs2_d; v.rs1_e = a_rs1_e; v.rs2_e = a_rs2_e;
        v.rd_e = a_rd_e; v.rsrc = a_rsrc; v.pc = a_pc; v.rd_m = a_rd_m; v.rw_m = a_rw_m;
        v.rd_w = a_rd_w; v.rw_w = a_rw_w; v.mreq = a_mreq; v.mrdy = a_mrdy;
        v.fa = a_fa; v.fb = a_fb; v.st = a_st; v.fl = a_fl; v.sc = a_sc;
        return v;
    endfunction

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = sb.pop_front();
        cmp(e.nm, "forward_a_e", 32'(forward_a_e), 32'(e.fa));
        cmp(e.nm, "forward_b_e", 32'(forward_b_e), 32'(e.fb));
        cmp(e.nm, "stall_fdem", 32'({stall_f, stall_d, stall_e, stall_m}), 32'(e.st));
        cmp(e.nm, "flush_dew", 32'({flush_d, flush_e, flush_w}), 32'(e.fl));
        cmp(e.nm, "mem_err", 32'(mem_err), 32'(e.err));
        if (e.sc >= 0)
            cmp(e.nm, "stall_cycles", 32'(stall_cycles), 32'(e.sc));
    endtask

    // Called at posedge+1 with inputs already driven; samples at the negedge
    // and returns at the next posedge+1.
    task automatic tick(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [3:0] st, input logic [2:0] fl, input logic err,
                        input int sc);
        exp_t e;
        e.nm = nm; e.fa = fa; e.fb = fb; e.st = st; e.fl = fl; e.err = err; e.sc = sc;
        sb.push_back(e);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        result_src_e = 2'b00; pcsrc_e = 0; regwrite_m = 0; regwrite_w = 0;
        mem_req_m = 0; mem_ready = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        rs1_d = v.rs1_d; rs2_d = v.rs2_d; rs1_e = v.rs1_e; rs2_e = v.rs2_e;
        rd_e = v.rd_e; result_src_e = v.rsrc; pcsrc_e = v.pc;
        rd_m = v.rd_m; regwrite_m = v.rw_m; rd_w = v.rd_w; regwrite_w = v.rw_w;
        mem_req_m = v.mreq; mem_ready = v.mrdy;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rs1d rs2d rs1e rs2e rde rsrc  pc rdm rwm rdw rww mreq mrdy fa     fb     st       fl     sc
        vecs[0]  = mk(0,   0,   0,   0,   0,  2'b00, 0, 0,  0,  0,  0,  0,   0,   2'b00, 2'b00, 4'b0000, 3'b000, 0);
        vecs[1]  = mk(0,   0,   7,   0,   0,  2'b00, 0, 7,  1,  7,  1,  0,   0,   2'b10, 2'b00, 4'b0000, 3'b000, 0);
        vecs[2]  = mk(0,   0,   7,   0,   0,  2'b00, 0, 0,  1,  7,  1,  0,   0,   2'b01, 2'b00, 4'b0000, 3'b000, 0);
        vecs[3]  = mk(0,   0,   0,   9,   0,  2'b00, 0, 9,  0,  9,  1,  0,   0,   2'b00, 2'b01, 4'b0000, 3'b000, 0);
        vecs[4]  = mk(0,   0,   3,   3,   0,  2'b00, 0, 3,  1,  3,  1,  0,   0,   2'b10, 2'b10, 4'b0000, 3'b000, 0);
        vecs[5]  = mk(0,   0,   0,   0,   0,  2'b00, 0, 0,  1,  0,  1,  0,   0,   2'b00, 2'b00, 4'b0000, 3'b000, 0);
        vecs[6]  = mk(5,   0,   0,   0,   5,  2'b01, 0, 0,  0,  0,  0,  0,   0,   2'b00, 2'b00, 4'b1100, 3'b010, 0);
        vecs[7]  = mk(0,   0,   0,   0,   0,  2'b01, 0, 0,  0,  0,  0,  0,   0,   2'b00, 2'b00, 4'b0000, 3'b000, 1);
        vecs[8]  = mk(5,   0,   0,   0,   5,  2'b10, 0, 0,  0,  0,  0,  0,   0,   2'b00, 2'b00, 4'b0000, 3'b000, 1);
        vecs[9]  = mk(0,   0,   0,   0,   0,  2'b00, 1, 0,  0,  0,  0,  0,   0,   2'b00, 2'b00, 4'b0000, 3'b110, 1);
        vecs[10] = mk(0,   4,   0,   0,   4,  2'b01, 1, 0,  0,  0,  0,  0,   0,   2'b00, 2'b00, 4'b1100, 3'b110, 1);
        vecs[11] = mk(0,   0,   2,   0,   0,  2'b00, 0, 2,  0,  2,  1,  1,   1,   2'b01, 2'b00, 4'b0000, 3'b000, 2);
        vecs[12] = mk(6,   6,   0,   0,   6,  2'b01, 0, 0,  0,  0,  0,  1,   1,   2'b00, 2'b00, 4'b1100, 3'b010, 2);

        // Reset state, with a load-use pattern present to prove outputs are gated.
        rst_n = 1'b0;
        zero_inputs();
        rs1_d = 5; rd_e = 5; result_src_e = 2'b01; pcsrc_e = 1;
        tick("reset", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 0);
        zero_inputs();
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            apply_vec(vecs[i]);
            tick($sformatf("vec%0d", i), vecs[i].fa, vecs[i].fb, vecs[i].st,
                 vecs[i].fl, 1'b0, vecs[i].sc);
        end

        // Memory wait: ready low 3 cycles then high; forwarding stays live.
        zero_inputs();
        rs1_e = 7; rd_m = 7; regwrite_m = 1; mem_req_m = 1;
        tick("wait3_c1", 2'b10, 2'b00, 4'b1111, 3'b001, 1'b0, 3);
        tick("wait3_c2", 2'b10, 2'b00, 4'b1111, 3'b001, 1'b0, 4);
        tick("wait3_c3", 2'b10, 2'b00, 4'b1111, 3'b001, 1'b0, 5);
        mem_ready = 1;
        tick("wait3_c4", 2'b10, 2'b00, 4'b1111, 3'b001, 1'b0, 6);
        zero_inputs();
        tick("wait3_run", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 7);

        // Branch resolved during a 2-cycle wait: flushed only after the wait.
        mem_req_m = 1;
        tick("br_c1", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 7);
        pcsrc_e = 1;
        tick("br_c2", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 8);
        mem_ready = 1;
        tick("br_c3", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 9);
        mem_req_m = 0; mem_ready = 0;
        tick("br_run", 2'b00, 2'b00, 4'b0000, 3'b110, 1'b0, 10);
        pcsrc_e = 0;
        tick("br_after", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 10);

        // Reset in the middle of a wait.
        mem_req_m = 1;
        tick("rmw_c1", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 10);
        tick("rmw_c2", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 11);
        rst_n = 0;
        rs1_d = 5; rd_e = 5; result_src_e = 2'b01; pcsrc_e = 1;
        tick("rmw_reset", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 0);
        rst_n = 1;
        rs1_d = 0; rd_e = 0; result_src_e = 2'b00; pcsrc_e = 0;
        tick("rmw_first", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 0);
        mem_ready = 1;
        tick("rmw_done", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, 1);
        zero_inputs();
        tick("rmw_run", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 2);

        // Timeout: 16 cycles with mem_ready low, then sticky ERROR.
        mem_req_m = 1;
        for (int i = 1; i <= 16; i++)
            tick($sformatf("to_c%0d", i), 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, -1);
        tick("to_err", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, -1);
        mem_req_m = 0; mem_ready = 1; pcsrc_e = 1;
        for (int i = 0; i < 3; i++)
            tick($sformatf("err_hold%0d", i), 2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, -1);
        rst_n = 0;
        tick("err_reset", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 0);
        rst_n = 1;
        zero_inputs();
        tick("err_run", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, 0);

        // Saturation: load-use stall held for 2^CNT_W+5 cycles in total.
        rs2_d = 12; rd_e = 12; result_src_e = 2'b01;
        repeat ((1 << CNT_W) + 4) @(posedge clk);
        #1;
        tick("sat", 2'b00, 2'b00, 4'b1100, 3'b010, 1'b0, (1 << CNT_W) - 1);
        tick("sat_hold", 2'b00, 2'b00, 4'b1100, 3'b010, 1'b0, (1 << CNT_W) - 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: max cycles waiting on mem_ready before error.
REQ-002 Parameter CNT_W, default 16: width of stall_cycles counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rs1_d, rs2_d  input  5 each  decode-stage source registers.
REQ-006 rs1_e, rs2_e, rd_e  input  5 each  execute-stage sources/destination.
REQ-007 result_src_e  input  2  execute-stage result select; 2'b01 = load.
REQ-008 pcsrc_e  input  1  taken branch or jump resolved in execute.
REQ-009 rd_m, regwrite_m  input  5, 1  memory-stage destination/write enable.
REQ-010 rd_w, regwrite_w  input  5, 1  writeback-stage destination/write enable.
REQ-011 mem_req_m  input  1  memory-stage instruction accesses data memory.
REQ-012 mem_ready  input  1  data memory completes the current access this cycle.
REQ-013 forward_a_e, forward_b_e  output  2 each  00 regfile, 10 from M, 01 from W.
REQ-014 stall_f, stall_d, stall_e, stall_m  output  1 each  hold stage register.
REQ-015 flush_d, flush_e, flush_w  output  1 each  load bubble into stage register.
REQ-016 mem_err  output  1  sticky memory-timeout error.
REQ-017 stall_cycles  output  CNT_W  saturating count of cycles with stall_f high.

Function
REQ-018 FSM states SHALL be RUN, MEM_WAIT, ERROR; encoding free.
REQ-019 Forwarding SHALL be combinational: M when regwrite_m, rd_m!=0, rd_m==rs_e; else W under same rule; M wins over W.
REQ-020 load_use SHALL = (result_src_e==2'b01) & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
REQ-021 RUN, mem_req_m & ~mem_ready: go MEM_WAIT same edge; timeout counter loads 1.
REQ-022 RUN, mem_req_m & mem_ready (or no mem_req_m): stay RUN, zero-wait access.
REQ-023 MEM_WAIT (and the RUN cycle triggering it): stall_f/d/e/m=1, flush_w=1, flush_d=flush_e=0.
REQ-024 MEM_WAIT, mem_ready=1: return to RUN next edge; counter cleared.
REQ-025 MEM_WAIT, counter reaches MEM_TIMEOUT with mem_ready=0: go ERROR; mem_err=1.
REQ-026 ERROR: all stalls=1, flush_w=1, mem_err=1; left only by reset.
REQ-027 RUN, no memory wait: stall_f=stall_d=flush_e=load_use; flush_d=pcsrc_e; flush_e also set by pcsrc_e.
REQ-028 Priority: memory wait > load_use > pcsrc_e flush; pcsrc_e arriving during MEM_WAIT is held in execute and applied the first RUN cycle after.
REQ-029 load_use and pcsrc_e together in RUN: stall_f=stall_d=1, flush_d=flush_e=1.
REQ-030 stall_cycles SHALL increment each cycle stall_f=1, saturating at all-ones; never wraps.
REQ-031 Forwarding outputs SHALL stay valid in all states; no combinational path mem_ready->forward_*.

Reset
REQ-032 rst_n low SHALL immediately force RUN, counters 0, mem_err=0, stall_cycles=0.
REQ-033 While rst_n low all stall_*/flush_* outputs SHALL be 0; reset mid-MEM_WAIT or in ERROR returns to RUN.
REQ-034 First edge after rst_n rises SHALL evaluate normal RUN rules.

Verification
REQ-035 Load x5 in E, rs1_d=5 -> one cycle stall_f=stall_d=flush_e=1; stall_cycles 0->1.
REQ-036 rd_m=rs1_e=7 regwrite_m=1, rd_w=7 regwrite_w=1 -> forward_a_e=10; rd_m=0 -> forward_a_e=01.
REQ-037 mem_req_m=1, mem_ready low 3 cycles then high -> stall_m=1, flush_w=1 for 4 cycles, then RUN.
REQ-038 pcsrc_e=1 during 2-cycle MEM_WAIT -> no flush in wait; flush_d=flush_e=1 first RUN cycle.
REQ-039 mem_ready held low 16 cycles -> mem_err=1, ERROR persists; rst_n pulse -> RUN, mem_err=0.
REQ-040 Stall held 2^CNT_W+5 cycles -> stall_cycles stays all-ones.
